// File: rtl/seq_det_ctrl.sv
// Serial pattern detector with configurable pattern, length, overlap mode and
// match-count target. Config is shadowed in IDLE; a run ends on target, abort or reset.
//
// state | meaning
// IDLE  | accepting config writes and start requests
// RUN   | shifting qualified bits and counting matches
// DONE  | target reached; done pulse, then back to IDLE
module seq_det_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             in,
    input  logic             in_valid,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       pat, pat_nxt;
    logic [3:0]       len, len_nxt;
    logic             ovl, ovl_nxt;
    logic [CNT_W-1:0] tgt, tgt_nxt;
    logic [7:0]       hist, hist_nxt;
    logic [3:0]       fill, fill_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             match_nxt, done_nxt, err_nxt;

    logic [7:0]       shift_hist;
    logic [3:0]       shift_fill;
    logic [8:0]       mask9;
    logic             hit;
    logic [CNT_W-1:0] cnt_inc;
    logic             cfg_bad;

    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pat       <= '0;
            len       <= '0;
            ovl       <= 1'b0;
            tgt       <= '0;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            match     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            pat       <= pat_nxt;
            len       <= len_nxt;
            ovl       <= ovl_nxt;
            tgt       <= tgt_nxt;
            hist      <= hist_nxt;
            fill      <= fill_nxt;
            match_cnt <= cnt_nxt;
            match     <= match_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pat_nxt   = pat;
        len_nxt   = len;
        ovl_nxt   = ovl;
        tgt_nxt   = tgt;
        hist_nxt  = hist;
        fill_nxt  = fill;
        cnt_nxt   = match_cnt;
        match_nxt = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;

        // Match is judged on the post-shift history so it registers on the completing edge
        shift_hist = {hist[6:0], in};
        shift_fill = (fill >= 4'd8) ? 4'd8 : fill + 4'd1;
        mask9      = (9'd1 << len) - 9'd1;
        hit        = (shift_fill >= len) && (((shift_hist ^ pat) & mask9[7:0]) == 8'd0);
        cnt_inc    = match_cnt + CNT_W'(1);
        cfg_bad    = (len == 4'd0) || (len > 4'd8) || (tgt == '0);

        case (state)
            IDLE: begin
                if (cfg_we) begin
                    pat_nxt = cfg_pattern;
                    len_nxt = cfg_len;
                    ovl_nxt = cfg_overlap;
                    tgt_nxt = cfg_target;
                end else if (start) begin
                    if (cfg_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt = RUN;
                        hist_nxt  = '0;
                        fill_nxt  = '0;
                        cnt_nxt   = '0;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (in_valid) begin
                    hist_nxt = shift_hist;
                    fill_nxt = shift_fill;
                    if (hit) begin
                        match_nxt = 1'b1;
                        cnt_nxt   = cnt_inc;
                        if (!ovl) fill_nxt = '0;
                        if (cnt_inc == tgt) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed testbench for seq_det_ctrl: hand-computed match/done/err/busy/count
// expectations for config, overlap modes, gaps, abort, reset and length boundaries.
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       rst, cfg_we, cfg_overlap, start, abort, in, in_valid;
    logic [7:0] cfg_pattern, cfg_target;
    logic [3:0] cfg_len;
    logic       busy, match, done, err;
    logic [7:0] match_cnt;

    int n_chk = 0;
    int n_err = 0;

    seq_det_ctrl #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cfg_target (cfg_target),
        .start      (start),
        .abort      (abort),
        .in         (in),
        .in_valid   (in_valid),
        .busy       (busy),
        .match      (match),
        .match_cnt  (match_cnt),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t);
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic b, input logic exp_m, input string tag);
        in = b; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk(tag, match, exp_m);
    endtask

    task automatic stream8(input logic [7:0] bits, input logic [7:0] exp_m, input string tag);
        for (int i = 7; i >= 0; i--) send(bits[i], exp_m[i], tag);
    endtask

    initial begin
        rst = 1'b1; cfg_we = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
        cfg_target = 0; start = 0; abort = 0; in = 0; in_valid = 0;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_match", match, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", match_cnt, 0);

        // start with no configuration
        go();
        chk("nocfg_err", err, 1);
        chk("nocfg_busy", busy, 0);
        step();
        chk("nocfg_err_clr", err, 0);
        chk("nocfg_busy2", busy, 0);

        // overlap=1, target=3: matches after bit 5 and bit 8
        cfg(8'h1B, 4'd5, 1'b1, 8'd3);
        go();
        chk("ovl_busy", busy, 1);
        chk("ovl_cnt0", match_cnt, 0);
        stream8(8'b11011011, 8'b00001001, "ovl_match");
        chk("ovl_cnt", match_cnt, 2);
        chk("ovl_busy_end", busy, 1);
        chk("ovl_done", done, 0);
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_cnt_held", match_cnt, 2);

        // overlap=0: single match
        cfg(8'h1B, 4'd5, 1'b0, 8'd3);
        go();
        stream8(8'b11011011, 8'b00001000, "novl_match");
        chk("novl_cnt", match_cnt, 1);
        abort = 1'b1; step(); abort = 1'b0;

        // target=2: done with the second match, then IDLE, count held
        cfg(8'h1B, 4'd5, 1'b1, 8'd2);
        go();
        stream8(8'b11011011, 8'b00001001, "tgt_match");
        chk("tgt_done", done, 1);
        chk("tgt_busy_done", busy, 0);
        step();
        chk("tgt_done_clr", done, 0);
        chk("tgt_busy_idle", busy, 0);
        chk("tgt_cnt_held", match_cnt, 2);
        step();
        chk("tgt_cnt_held2", match_cnt, 2);

        // abort on completing bit
        cfg(8'h1B, 4'd5, 1'b1, 8'd3);
        go();
        chk("abt_cnt_clr", match_cnt, 0);
        send(1, 0, "abt_pre"); send(1, 0, "abt_pre"); send(0, 0, "abt_pre"); send(1, 0, "abt_pre");
        in = 1'b1; in_valid = 1'b1; abort = 1'b1;
        step();
        in_valid = 1'b0; abort = 1'b0;
        chk("abt_match", match, 0);
        chk("abt_done", done, 0);
        chk("abt_busy", busy, 0);
        chk("abt_cnt", match_cnt, 0);

        // gaps do not disturb detection
        go();
        send(1, 0, "gap_bit"); send(1, 0, "gap_bit");
        for (int i = 0; i < 3; i++) begin
            in = 1'b0; step();
            chk("gap_idle", match, 0);
        end
        send(0, 0, "gap_bit"); send(1, 0, "gap_bit"); send(1, 1, "gap_last");
        chk("gap_cnt", match_cnt, 1);
        abort = 1'b1; step(); abort = 1'b0;

        // cfg_we wins over start; then len=0 is rejected
        cfg_we = 1'b1; start = 1'b1; cfg_pattern = 8'h01; cfg_len = 4'd0;
        cfg_overlap = 1'b0; cfg_target = 8'd1;
        step();
        cfg_we = 1'b0; start = 1'b0;
        chk("cfgstart_busy", busy, 0);
        chk("cfgstart_err", err, 0);
        go();
        chk("len0_err", err, 1);
        chk("len0_busy", busy, 0);
        cfg(8'h01, 4'd9, 1'b0, 8'd1);
        go();
        chk("len9_err", err, 1);
        cfg(8'h01, 4'd1, 1'b0, 8'd0);
        go();
        chk("tgt0_err", err, 1);

        // len=8 with leading filler; cfg_we in RUN ignored
        cfg(8'hA5, 4'd8, 1'b1, 8'd1);
        go();
        cfg(8'h00, 4'd1, 1'b1, 8'd1);
        send(0, 0, "len8_lead"); send(1, 0, "len8_lead");
        stream8(8'hA5, 8'b00000001, "len8_match");
        chk("len8_done", done, 1);
        chk("len8_cnt", match_cnt, 1);
        step();

        // reset mid-run
        go();
        send(1, 0, "rstrun_bit"); send(0, 0, "rstrun_bit");
        rst = 1'b1; step(); rst = 1'b0;
        chk("rstrun_busy", busy, 0);
        chk("rstrun_done", done, 0);
        chk("rstrun_cnt", match_cnt, 0);
        go();
        chk("rstrun_cfg_clr_err", err, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of cfg_target and match_cnt.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cfg_we  input  1  config write strobe.
REQ-005 SHALL have port cfg_pattern  input  8  pattern; bit len-1 is the first serial bit, bit 0 the last.
REQ-006 SHALL have port cfg_len  input  4  pattern length; legal values are 1..8.
REQ-007 SHALL have port cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-008 SHALL have port cfg_target  input  CNT_W  match count that ends a run; legal values are nonzero.
REQ-009 SHALL have port start  input  1  begin a run.
REQ-010 SHALL have port abort  input  1  terminate a run.
REQ-011 SHALL have port in  input  1  serial data bit.
REQ-012 SHALL have port in_valid  input  1  qualifies in.
REQ-013 SHALL have port busy  output  1  high while in RUN.
REQ-014 SHALL have port match  output  1  one-cycle pulse per detected pattern.
REQ-015 SHALL have port match_cnt  output  CNT_W  matches in the current or last run.
REQ-016 SHALL have port done  output  1  one-cycle pulse when the target is reached.
REQ-017 SHALL have port err  output  1  one-cycle pulse when start is rejected.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and DONE, with all outputs registered.
REQ-019 SHALL latch cfg_* into shadow registers on cfg_we only in IDLE; cfg_we in RUN or DONE is ignored.
REQ-020 SHALL, on start in IDLE with shadow len 0, len >8 or target 0, pulse err for 1 cycle and stay in IDLE.
REQ-021 SHALL, on a legal start in IDLE, enter RUN next edge, clear history, clear fill count and clear match_cnt.
REQ-022 SHALL, when start and cfg_we occur in the same IDLE cycle, write the config and ignore start.
REQ-023 SHALL, in RUN with in_valid=1, shift in into the 8-bit history (LSB = newest) and set fill = min(fill+1, 8).
REQ-024 SHALL detect a match when the updated fill >= len and the low len bits of the updated history equal the low len bits of the pattern.
REQ-025 SHALL register match on the same edge that samples the completing bit, so match is high the following cycle for exactly 1 cycle.
REQ-026 SHALL, in RUN with in_valid=0, hold history, fill and count with match=0.
REQ-027 SHALL, on a match with overlap=0, reset fill to 0 so no bit is reused; with overlap=1, retain fill.
REQ-028 SHALL increment match_cnt on each match; when the new value equals target, enter DONE on the same edge.
REQ-029 SHALL, in DONE, assert done for 1 cycle, keep busy=0, ignore in_valid, then return to IDLE.
REQ-030 SHALL hold match_cnt after a run until the next legal start.
REQ-031 SHALL give abort in RUN priority over in_valid: the bit is discarded, no match occurs, the next state is IDLE, and there is no done pulse.
REQ-032 SHALL ignore abort in IDLE or DONE, and ignore start in RUN or DONE.
REQ-033 SHALL make busy combinationally equal to (state==RUN).

Reset
REQ-034 SHALL, on rst=1 at a clock edge, force IDLE, with match, done and err at 0, match_cnt 0, history 0 and fill 0.
REQ-035 SHALL, on reset, clear shadow pattern, len, overlap and target to 0, so start before configuration pulses err.
REQ-036 SHALL give rst priority over all other inputs, including mid-run, where a run is discarded with no done pulse.

Verification
REQ-037 SHALL cover: config pattern=8'h1B, len=5, overlap=1, target=3; stream 1,1,0,1,1,0,1,1 -> match pulses after the 5th and 8th bits, match_cnt=2, busy=1.
REQ-038 SHALL cover: same stream with overlap=0 -> one match after the 5th bit, match_cnt=1.
REQ-039 SHALL cover: overlap=1, target=2, stream 11011011 -> done pulse the cycle after the 2nd match, then IDLE, with match_cnt held at 2.
REQ-040 SHALL cover: start after reset with no config -> err=1 for 1 cycle, busy stays 0.
REQ-041 SHALL cover: abort asserted with in_valid=1 on the completing bit -> no match, no done, busy=0 next cycle.
REQ-042 SHALL cover: stream 1,1,gap(in_valid=0 for 3 cycles),0,1,1 with len=5 -> exactly one match, with gaps not affecting detection.
